noc_tree_input_port: RTL and testbench

//  Clocked, parametrised input port for a tree NoC router node. Buffers packets from one upstream

---
 rtl/noc_tree_pkg.sv | 42 ++++
 rtl/noc_sync_fifo.sv | 56 +++++
 rtl/noc_tree_input_port.sv | 98 +++++++++
 tb/tb_noc_tree_input_port.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_tree_pkg.sv
// Purpose: shared constants, field typedefs and the route decode helper for the tree NoC input port.
// Latency: none; declarations and a pure combinational function only.
// Backpressure: not applicable.
// Contents: default packet/field geometry, dest_t, route_onehot_t, route_decode().
package noc_tree_pkg;

  localparam int DEF_WIDTH_PACKET = 14;
  localparam int DEF_ADDR_LSB     = 8;
  localparam int DEF_ADDR_W       = 3;
  localparam int DEF_CHILD_W      = 1;
  localparam int DEF_NUM_CHILD    = 2 ** DEF_CHILD_W;
  localparam int DEF_NODE_PREFIX  = 0;
  localparam int DEF_DEPTH        = 4;

  // Widest one-hot route the helper can produce; callers slice down to NUM_CHILD+1.
  localparam int ROUTE_MAX = 64;

  typedef logic [DEF_ADDR_W-1:0]  dest_t;
  typedef logic [DEF_NUM_CHILD:0] route_onehot_t;

  // dest must arrive zero-extended from an addr_w-bit field. Low child_w bits pick the
  // child; the remaining high bits must equal prefix for the packet to stay in this subtree.
  // With no prefix bits (addr_w == child_w) everything stays local.
  function automatic logic [ROUTE_MAX-1:0] route_decode(input logic [31:0] dest,
                                                        input int addr_w,
                                                        input int child_w,
                                                        input int prefix);
    logic [31:0] sel;
    logic [31:0] hi;
    logic [31:0] parent;
    route_decode = '0;
    sel    = dest & ((32'd1 << child_w) - 32'd1);
    hi     = dest >> child_w;
    parent = 32'd1 << child_w;
    if (addr_w == child_w || hi == 32'(prefix)) begin
      route_decode[sel[5:0]] = 1'b1;
    end else begin
      route_decode[parent[5:0]] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Purpose: generic synchronous FIFO with occupancy count, head presented combinationally.
// Latency: pushed word is visible at pop_data from the following cycle.
// Backpressure: caller must honour full/empty; push when full and pop when empty are dropped.
// Ports: clk, rst (async active-high), push/push_data, pop/pop_data, full, empty, count.
module noc_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_tree_input_port.sv
// Purpose: tree NoC router input port; FIFO-buffers one upstream link and steers each packet to a child or the parent.
// Latency: packet accepted at edge k drives out_valid from edge k+1 at the earliest; 1 packet/cycle sustained.
// Backpressure: in_ready drops when the FIFO is full; a stalled head blocks everything behind it.
// Ports: clk, rst, in_valid/in_ready/in_data, out_valid[NUM_CHILD:0]/out_ready/out_data, fifo_count,
//        pkt_cnt[NUM_CHILD+1] (16-bit per-link transfer counters) only when ROUTE_STATS_EN is defined.
module noc_tree_input_port
  import noc_tree_pkg::*;
#(
  parameter  int WIDTH_PACKET = DEF_WIDTH_PACKET,
  parameter  int ADDR_LSB     = DEF_ADDR_LSB,
  parameter  int ADDR_W       = DEF_ADDR_W,
  parameter  int CHILD_W      = DEF_CHILD_W,
  parameter  int NODE_PREFIX  = DEF_NODE_PREFIX,
  parameter  int DEPTH        = DEF_DEPTH,
  localparam int NUM_CHILD    = 2 ** CHILD_W,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_PACKET-1:0] in_data,
  output logic [NUM_CHILD:0]      out_valid,
  input  logic [NUM_CHILD:0]      out_ready,
  output logic [WIDTH_PACKET-1:0] out_data,
  output logic [CNT_W-1:0]        fifo_count
`ifdef ROUTE_STATS_EN
  ,
  output logic [15:0]             pkt_cnt [NUM_CHILD+1]
`endif
);

  logic [WIDTH_PACKET-1:0] head;
  logic [ADDR_W-1:0]       head_dest;
  logic [NUM_CHILD:0]      head_route;
  logic [NUM_CHILD:0]      stage_route;
  logic                    stage_vld;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    xfer;

  // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;

  noc_sync_fifo #(
    .WIDTH (WIDTH_PACKET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Route is resolved once, as the head moves into the output stage.
  assign head_dest  = head[ADDR_LSB +: ADDR_W];
  assign head_route = (NUM_CHILD+1)'(route_decode(32'(head_dest), ADDR_W, CHILD_W, NODE_PREFIX));

  // stage_route is one-hot, so only the ready of the selected link can complete a transfer.
  assign out_valid = stage_vld ? stage_route : '0;
  assign xfer      = |(out_valid & out_ready);
  assign pop       = !fifo_empty && (!stage_vld || xfer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld   <= 1'b0;
      stage_route <= '0;
      out_data    <= '0;
    end else if (pop) begin
      stage_vld   <= 1'b1;
      stage_route <= head_route;
      out_data    <= head;
    end else if (xfer) begin
      stage_vld   <= 1'b0;
    end
  end

`ifdef ROUTE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_CHILD; i++) pkt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i <= NUM_CHILD; i++) begin
        if (out_valid[i] && out_ready[i]) pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_tree_input_port.sv
// Purpose: self-checking bench for noc_tree_input_port at default parameters (NODE_PREFIX=0).
// Latency: reference model advances once per rising edge; outputs sampled 1 time unit after it.
// Backpressure: exercised via out_ready tables, full-FIFO fill, HOL stall and random traffic.
module tb_noc_tree_input_port;

  localparam int W  = 14;
  localparam int DP = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [2:0]    out_valid;
  logic [2:0]    out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    fifo_count;
`ifdef ROUTE_STATS_EN
  logic [15:0]   pkt_cnt [3];
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: queue of packets waiting in the FIFO plus the single output stage.
  logic [W-1:0]  mq[$];
  bit            sv;
  logic [W-1:0]  sd;
  int unsigned   mcnt[3];

  typedef struct {
    logic [2:0] dest;
    logic [2:0] exp_vld;
  } rvec_t;
  rvec_t tbl[8];

  logic [W-1:0] spk[16];
  logic [W-1:0] pa;
  logic [W-1:0] pb;

  noc_tree_input_port dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count)
`ifdef ROUTE_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Destination rule at NODE_PREFIX=0, CHILD_W=1: dest 0/1 stay local, anything else goes up.
  function automatic logic [2:0] ref_route(input logic [W-1:0] p);
    logic [2:0] d;
    d = p[10:8];
    if (d[2:1] == 2'd0) return d[0] ? 3'b010 : 3'b001;
    return 3'b100;
  endfunction

  function automatic logic [W-1:0] mk(input logic [2:0] d);
    logic [31:0] r;
    r = $urandom;
    return {r[13:11], d, r[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: model evaluates the pre-edge inputs, DUT is compared just after the edge.
  task automatic tick();
    bit         xf;
    bit         ps;
    bit         ld;
    logic [2:0] r;
    r  = ref_route(sd);
    xf = sv && ((out_ready & r) != 3'b000);
    ps = in_valid && !rst && (mq.size() < DP);
    ld = (mq.size() > 0) && (!sv || xf);
    @(posedge clk);
    #1;
    if (xf) mcnt[r[2] ? 2 : (r[1] ? 1 : 0)]++;
    if (ld) begin
      sd = mq.pop_front();
      sv = 1'b1;
    end else if (xf) begin
      sv = 1'b0;
    end
    if (ps) mq.push_back(in_data);
    chk("model_out_valid", 32'(out_valid), sv ? 32'(ref_route(sd)) : 32'd0);
    if (sv) chk("model_out_data", 32'(out_data), 32'(sd));
    chk("model_fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("model_in_ready", 32'(in_ready), (mq.size() < DP) ? 32'd1 : 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    sv = 1'b0;
    sd = '0;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 3'b000;
    sv        = 1'b0;
    sd        = '0;

    tbl[0] = '{3'd0, 3'b001};
    tbl[1] = '{3'd1, 3'b010};
    tbl[2] = '{3'd2, 3'b100};
    tbl[3] = '{3'd3, 3'b100};
    tbl[4] = '{3'd4, 3'b100};
    tbl[5] = '{3'd5, 3'b100};
    tbl[6] = '{3'd6, 3'b100};
    tbl[7] = '{3'd7, 3'b100};

    #2;
    do_reset();

    // Routing table; ready on the unselected links alone must not complete the transfer.
    for (int i = 0; i < 8; i++) begin
      in_data   = mk(tbl[i].dest);
      in_valid  = 1'b1;
      out_ready = 3'b000;
      tick();
      in_valid  = 1'b0;
      tick();
      chk("route_vld", 32'(out_valid), 32'(tbl[i].exp_vld));
      out_ready = ~tbl[i].exp_vld;
      tick();
      chk("route_unsel_ignored", 32'(out_valid), 32'(tbl[i].exp_vld));
      out_ready = tbl[i].exp_vld;
      tick();
      chk("route_done", 32'(out_valid), 32'd0);
    end

    // Reset while three packets are queued and the upstream is still offering.
    out_ready = 3'b000;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = mk(3'($urandom_range(0, 7)));
      tick();
    end
    do_reset();
    in_valid = 1'b0;
    tick();
    chk("post_rst_count", 32'(fifo_count), 32'd0);

    // Fill: five packets land as four in the FIFO plus one in the stage; the sixth is held off.
    do_reset();
    out_ready = 3'b000;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = mk(3'($urandom_range(0, 7)));
      tick();
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_stage_vld", 32'(out_valid != 3'b000), 32'd1);
    in_data = mk(3'd1);
    tick();
    tick();
    chk("full_held_count", 32'(fifo_count), 32'd4);
    in_valid  = 1'b0;
    out_ready = 3'b111;
    for (int i = 0; i < 8; i++) tick();
    chk("full_drained_vld", 32'(out_valid), 32'd0);
    chk("full_drained_count", 32'(fifo_count), 32'd0);

    // Streaming: 16 back-to-back packets, one out per cycle from the edge after the first push.
    out_ready = 3'b111;
    for (int i = 0; i < 16; i++) spk[i] = mk(3'($urandom_range(0, 7)));
    for (int t = 1; t <= 17; t++) begin
      in_valid = (t <= 16);
      in_data  = spk[(t <= 16) ? t - 1 : 15];
      tick();
      if (t == 1) chk("stream_first_latency", 32'(out_valid), 32'd0);
      else begin
        chk("stream_vld", 32'(out_valid), 32'(ref_route(spk[t-2])));
        chk("stream_data", 32'(out_data), 32'(spk[t-2]));
      end
    end
    in_valid = 1'b0;
    tick();

    // HOL: child0 stalled for 3 cycles; a parent packet behind it must wait.
    pa = mk(3'd0);
    pb = mk(3'd6);
    out_ready = 3'b110;
    in_valid  = 1'b1;
    in_data   = pa;
    tick();
    in_data   = pb;
    tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hol_data_stable", 32'(out_data), 32'(pa));
      chk("hol_vld", 32'(out_valid), 32'b001);
    end
    out_ready = 3'b111;
    tick();
    chk("hol_parent_next", 32'(out_data), 32'(pb));
    chk("hol_parent_vld", 32'(out_valid), 32'b100);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = mk(3'($urandom_range(0, 7)));
      out_ready = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0;

`ifdef ROUTE_STATS_EN
    // 65536 child0 transfers wrap the counter back to zero.
    do_reset();
    out_ready = 3'b111;
    in_valid  = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_data = mk(3'd0);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stats_model_child0", mcnt[0], 32'd65536);
    chk("stats_wrap", 32'(pkt_cnt[0]), 32'd0);

    // 2 child0, 1 child1, 3 parent.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = (i < 2) ? mk(3'd0) : ((i == 2) ? mk(3'd1) : mk(3'd5));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stats_child0", 32'(pkt_cnt[0]), 32'd2);
    chk("stats_child1", 32'(pkt_cnt[1]), 32'd1);
    chk("stats_parent", 32'(pkt_cnt[2]), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
